// File: rtl/mem_responder_pkg.sv
// Shared defaults, FSM state encoding and captured-request payload for the mem responder.
package mem_responder_pkg;

    localparam int unsigned MEM_WIDTH      = 16;
    localparam int unsigned MEM_DEPTH      = 16;
    localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_CNT_WIDTH  = 16;
    localparam int unsigned MEM_WS_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef struct packed {
        logic                      wr_rd;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_WIDTH-1:0]      data;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready mem bus between an initiator (master) and the memory-side responder (slave).
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH      = MEM_WIDTH,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned WS_WIDTH   = MEM_WS_WIDTH
);

    logic                  valid_i;
    logic                  wr_rd_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wr_data_i;
    logic [WS_WIDTH-1:0]   wait_cyc_i;
    logic                  ready_o;
    logic [WIDTH-1:0]      rd_data_o;
    logic                  abort_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, wr_data_i, wait_cyc_i,
        input  ready_o, rd_data_o, abort_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, wr_data_i, wait_cyc_i,
        output ready_o, rd_data_o, abort_o
    );

endinterface

// File: rtl/mem_responder_storage.sv
// DEPTH x WIDTH word array: async clear, one synchronous write port, one combinational read port.
module mem_responder_storage
    import mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH      = MEM_WIDTH,
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request, inserts programmable wait states, then strobes
// ready_o for one cycle and commits the transfer on the handshake edge.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH      = MEM_WIDTH,
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned CNT_WIDTH  = MEM_CNT_WIDTH,
    parameter int unsigned WS_WIDTH   = MEM_WS_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_responder_if.slave       bus,
    output logic [CNT_WIDTH-1:0] wr_cnt_o,
    output logic [CNT_WIDTH-1:0] rd_cnt_o
);

    mem_resp_state_t       state_q;
    mem_req_t              req_q;
    logic [WS_WIDTH-1:0]   ws_cnt_q;
    logic                  ready_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic                  abort_q;
    logic [CNT_WIDTH-1:0]  wr_cnt_q;
    logic [CNT_WIDTH-1:0]  rd_cnt_q;

    logic                  commit_c;
    logic                  we_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic [WIDTH-1:0]      rdata_c;

    // A write lands in the array on the same edge the handshake completes.
    assign commit_c = (state_q == RESP) && bus.valid_i;
    assign we_c     = commit_c && req_q.wr_rd;

    // Zero-wait reads enter RESP straight from IDLE, before the address is in req_q.
    assign rd_addr_c = (state_q == IDLE) ? bus.addr_i : ADDR_WIDTH'(req_q.addr);

    mem_responder_storage #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (we_c),
        .waddr   (ADDR_WIDTH'(req_q.addr)),
        .wdata   (WIDTH'(req_q.data)),
        .raddr   (rd_addr_c),
        .rdata_c (rdata_c)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ws_cnt_q  <= '0;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
            abort_q   <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        req_q.wr_rd <= bus.wr_rd_i;
                        req_q.addr  <= MEM_ADDR_WIDTH'(bus.addr_i);
                        req_q.data  <= MEM_WIDTH'(bus.wr_data_i);
                        ws_cnt_q    <= bus.wait_cyc_i;
                        if (bus.wait_cyc_i == '0) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            if (!bus.wr_rd_i) begin
                                rd_data_q <= rdata_c;
                            end
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.valid_i) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                    end else if (ws_cnt_q == WS_WIDTH'(1)) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        if (!req_q.wr_rd) begin
                            rd_data_q <= rdata_c;
                        end
                    end else begin
                        ws_cnt_q <= ws_cnt_q - WS_WIDTH'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (bus.valid_i) begin
                        // Counters hold at all-ones instead of wrapping.
                        if (req_q.wr_rd) begin
                            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o   = ready_q;
    assign bus.rd_data_o = rd_data_q;
    assign bus.abort_o   = abort_q;
    assign wr_cnt_o      = wr_cnt_q;
    assign rd_cnt_o      = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected responses, reference memory and counters.
module tb_mem_responder;
    import mem_responder_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] data;
        int unsigned lat;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    mem_responder_if #(.WIDTH(16), .ADDR_WIDTH(4), .WS_WIDTH(4)) bus ();
    mem_responder_if #(.WIDTH(16), .ADDR_WIDTH(4), .WS_WIDTH(4)) bus_sat ();

    logic [15:0] wr_cnt, rd_cnt;
    logic [1:0]  sat_wr_cnt, sat_rd_cnt;

    exp_t        sb[$];
    logic [15:0] model_mem [16];
    int unsigned exp_wr = 0;
    int unsigned exp_rd = 0;
    int unsigned n_cmp  = 0;
    int unsigned n_bad  = 0;

    always #5 clk_i = ~clk_i;

    // Second instance sees identical traffic but has 2-bit counters.
    assign bus_sat.valid_i    = bus.valid_i;
    assign bus_sat.wr_rd_i    = bus.wr_rd_i;
    assign bus_sat.addr_i     = bus.addr_i;
    assign bus_sat.wr_data_i  = bus.wr_data_i;
    assign bus_sat.wait_cyc_i = bus.wait_cyc_i;

    mem_responder u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bus      (bus),
        .wr_cnt_o (wr_cnt),
        .rd_cnt_o (rd_cnt)
    );

    mem_responder #(.CNT_WIDTH(2)) u_sat (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bus      (bus_sat),
        .wr_cnt_o (sat_wr_cnt),
        .rd_cnt_o (sat_rd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0;
        exp_wr = 0;
        exp_rd = 0;
        sb.delete();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, "_sat_wr_cnt"}, 32'(sat_wr_cnt), 32'((exp_wr > 3) ? 3 : exp_wr));
        check({tag, "_sat_rd_cnt"}, 32'(sat_rd_cnt), 32'((exp_rd > 3) ? 3 : exp_rd));
    endtask

    // One complete transfer; payload is scrambled after acceptance to prove it was captured.
    task automatic txn(input string tag, input logic wr, input int unsigned addr,
                       input logic [15:0] data, input int unsigned ws);
        exp_t        e;
        int unsigned n;
        bit          seen;
        e.wr   = wr;
        e.lat  = ws + 1;
        e.data = wr ? data : model_mem[addr];
        sb.push_back(e);
        bus.valid_i    = 1'b1;
        bus.wr_rd_i    = wr;
        bus.addr_i     = 4'(addr);
        bus.wr_data_i  = data;
        bus.wait_cyc_i = 4'(ws);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 1) begin
                bus.addr_i     = ~bus.addr_i;
                bus.wr_data_i  = ~data;
                bus.wait_cyc_i = 4'($urandom_range(0, 15));
            end
            if (bus.ready_o === 1'b1) seen = 1'b1;
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        if (!e.wr) check({tag, "_rd_data"}, 32'(bus.rd_data_o), 32'(e.data));
        tick();
        if (wr) begin
            model_mem[addr] = data;
            exp_wr++;
        end else begin
            exp_rd++;
        end
        bus.valid_i = 1'b0;
        check({tag, "_ready_one_cycle"}, 32'(bus.ready_o), 32'd0);
        if (!e.wr) check({tag, "_rd_data_hold"}, 32'(bus.rd_data_o), 32'(e.data));
        check_counters(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.valid_i    = 1'b0;
        bus.wr_rd_i    = 1'b0;
        bus.addr_i     = 4'h0;
        bus.wr_data_i  = 16'h0;
        bus.wait_cyc_i = 4'h0;
        model_reset();

        // Reset state
        repeat (2) tick();
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data_o), 32'd0);
        check("rst_abort", 32'(bus.abort_o), 32'd0);
        check_counters("rst");
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        txn("w3_rd7", 1'b0, 7, 16'h0, 3);
        txn("w0_wr3", 1'b1, 3, 16'hA5A5, 0);
        txn("w0_rd3", 1'b0, 3, 16'h0, 0);

        for (int i = 0; i < 16; i++) txn("b2b_wr", 1'b1, i, 16'(i * 16'h1111), 0);
        for (int i = 0; i < 16; i++) txn("b2b_rd", 1'b0, i, 16'h0, i % 3);

        // Reset while a write to @9 sits in RESP
        bus.valid_i    = 1'b1;
        bus.wr_rd_i    = 1'b1;
        bus.addr_i     = 4'd9;
        bus.wr_data_i  = 16'h1234;
        bus.wait_cyc_i = 4'd0;
        tick();
        check("mid_rst_resp", 32'(bus.ready_o), 32'd1);
        rst_i = 1'b0;
        #1;
        bus.valid_i = 1'b0;
        check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
        check("mid_rst_rd_data", 32'(bus.rd_data_o), 32'd0);
        model_reset();
        check_counters("mid_rst");
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) txn("sat_wr", 1'b1, 10 + i, 16'(16'hC000 + i), 0);
        check("sat_wr_final", 32'(sat_wr_cnt), 32'd3);
        check("sat_rd_final", 32'(sat_rd_cnt), 32'd0);
        txn("rd9_after_rst", 1'b0, 9, 16'h0, 1);

        // Drop valid while waiting: abort pulse, no write
        bus.valid_i    = 1'b1;
        bus.wr_rd_i    = 1'b1;
        bus.addr_i     = 4'd2;
        bus.wr_data_i  = 16'hDEAD;
        bus.wait_cyc_i = 4'd5;
        repeat (3) tick();
        check("abort_pre", 32'(bus.abort_o), 32'd0);
        bus.valid_i = 1'b0;
        tick();
        check("abort_pulse", 32'(bus.abort_o), 32'd1);
        check("abort_no_ready", 32'(bus.ready_o), 32'd0);
        tick();
        check("abort_one_cycle", 32'(bus.abort_o), 32'd0);
        check_counters("abort");
        txn("abort_rd2", 1'b0, 2, 16'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
